// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle 4-bit restoring divider with signed and unsigned modes.
// A start pulse in IDLE captures the operands. The divider then runs one
// shift-subtract step per clock for four clocks (CALC). A single FIX cycle
// applies the result signs. DONE then pulses for one cycle.
// A zero divisor skips CALC/FIX and goes straight to DONE.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over start)
//   start      division request, honoured only in IDLE
//   S          1 = signed two's-complement operands, 0 = unsigned
//   i1         dividend (4 bits)
//   i2         divisor  (4 bits)
//   quotient   result quotient, held until the next accepted start
//   remainder  result remainder, held until the next accepted start
//   busy       high in CALC and FIX
//   done       one-cycle pulse in DONE: results valid
//   dbz        divide-by-zero flag for the last result
//   ovf        signed-overflow flag for the last result (-8 / -1)
// -----------------------------------------------------------------------------
module seq_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       S,
  input  logic [3:0] i1,
  input  logic [3:0] i2,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       dbz,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  // Operation context captured at the accepted start edge.
  logic       sgn;        // signed mode for the operation in progress
  logic       neg_a;      // dividend was negative (signed mode only)
  logic       neg_b;      // divisor was negative (signed mode only)
  logic       ovf_case;   // operands were exactly -8 / -1 in signed mode
  logic [3:0] mag_b;      // divisor magnitude
  logic [3:0] dvd;        // dividend magnitude, shifted out MSB-first
  logic [3:0] prem;       // partial remainder carried between steps
  logic [3:0] qacc;       // quotient bits, shifted in LSB-first
  logic [1:0] count;      // iteration count within CALC

  // Operand magnitudes at the input. In signed mode, a negative value is
  // replaced by its two's complement. -8 maps to 4'b1000, which is +8 read
  // as unsigned, so the unsigned datapath handles it correctly.
  logic [3:0] mag_a_in;
  logic [3:0] mag_b_in;
  logic       start_dbz;

  // One restoring step.
  logic [4:0] shifted;
  logic [4:0] diff;
  logic [3:0] prem_step;
  logic       q_bit;

  // Sign correction applied in FIX.
  logic [3:0] q_fix;
  logic [3:0] r_fix;

  always_comb begin
    mag_a_in  = (S && i1[3]) ? 4'd0 - i1 : i1;
    mag_b_in  = (S && i2[3]) ? 4'd0 - i2 : i2;
    start_dbz = (i2 == 4'd0);
  end

  // The partial remainder stays below the divisor. The shifted value is
  // therefore less than twice the divisor, so shifted - divisor lies in
  // -15..14 and fits a 5-bit two's-complement word. Bit 4 is the sign of
  // the trial subtraction.
  always_comb begin
    shifted   = {prem, dvd[3]};
    diff      = shifted - {1'b0, mag_b};
    q_bit     = ~diff[4];
    prem_step = q_bit ? diff[3:0] : shifted[3:0];
  end

  // The divider produces magnitudes. The quotient truncates toward zero.
  // The remainder takes the sign of the dividend.
  always_comb begin
    q_fix = (sgn && (neg_a ^ neg_b)) ? 4'd0 - qacc : qacc;
    r_fix = (sgn && neg_a)           ? 4'd0 - prem : prem;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking (<=) assignments. All flops
  // then update from values sampled at the same edge, whatever the block order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next gets a default before the case statement. Every path
  // therefore assigns it, and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) state_next = start_dbz ? DONE : CALC;
      end
      CALC: begin
        if (count == 2'd3) state_next = FIX;
      end
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      CALC, FIX: busy = 1'b1;
      DONE:      done = 1'b1;
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sgn       <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      ovf_case  <= 1'b0;
      mag_b     <= 4'd0;
      dvd       <= 4'd0;
      prem      <= 4'd0;
      qacc      <= 4'd0;
      count     <= 2'd0;
      quotient  <= 4'd0;
      remainder <= 4'd0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sgn      <= S;
            neg_a    <= S & i1[3];
            neg_b    <= S & i2[3];
            ovf_case <= S && (i1 == 4'b1000) && (i2 == 4'b1111);
            mag_b    <= mag_b_in;
            dvd      <= mag_a_in;
            prem     <= 4'd0;
            qacc     <= 4'd0;
            count    <= 2'd0;
            ovf      <= 1'b0;
            dbz      <= start_dbz;
            // A zero divisor returns the fixed pattern immediately.
            if (start_dbz) begin
              quotient  <= 4'hF;
              remainder <= i1;
            end
          end
        end
        CALC: begin
          prem  <= prem_step;
          qacc  <= {qacc[2:0], q_bit};
          dvd   <= {dvd[2:0], 1'b0};
          count <= count + 2'd1;
        end
        FIX: begin
          // -8 / -1 yields +8. That value wraps to 4'b1000, which is the
          // required overflow result, so only the flag needs setting here.
          quotient  <= q_fix;
          remainder <= r_fix;
          ovf       <= ovf_case;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Self-checking bench for seq_divider. Expected results come from an
// integer-arithmetic reference model. Checks cover reset, directed cases,
// abort, ignored starts and randomized operations.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic       S;
  logic [3:0] i1;
  logic [3:0] i2;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       dbz;
  logic       ovf;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .S         (S),
    .i1        (i1),
    .i2        (i2),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: plain integer division. SystemVerilog integer division
  // truncates toward zero, and % takes the sign of the dividend.
  function automatic void model(input logic s, input logic [3:0] a, input logic [3:0] b,
                                output logic [3:0] q, output logic [3:0] r,
                                output logic dz, output logic ov);
    int ai, bi, qi, ri;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 4'd0) begin
      q  = 4'hF;
      r  = a;
      dz = 1'b1;
    end else begin
      ai = s ? int'($signed(a)) : int'(a);
      bi = s ? int'($signed(b)) : int'(b);
      qi = ai / bi;
      ri = ai % bi;
      ov = s && (ai == -8) && (bi == -1);
      q  = qi[3:0];
      r  = ri[3:0];
    end
  endfunction

  // Issue one division and check its result, latency, busy time, the
  // single done pulse and the hold of the results afterwards. Operands
  // are scrambled right after the start edge.
  task automatic run_div(input string name, input logic s, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] eq, er;
    logic       ed, eo;
    int         cycles, busy_cnt;
    model(s, a, b, eq, er, ed, eo);
    @(negedge clk);
    S = s; i1 = a; i2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    S  = 1'($urandom);
    i1 = 4'($urandom);
    i2 = 4'($urandom);
    cycles   = 1;
    busy_cnt = 0;
    while (!done && cycles < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      cycles++;
    end
    check({name, " latency"},   cycles,    ed ? 1 : 6);
    check({name, " busy_cyc"},  busy_cnt,  ed ? 0 : 5);
    check({name, " quotient"},  quotient,  eq);
    check({name, " remainder"}, remainder, er);
    check({name, " dbz"},       dbz,       ed);
    check({name, " ovf"},       ovf,       eo);
    @(posedge clk); #1;
    check({name, " done_off"},  done,      1'b0);
    repeat (2) @(posedge clk);
    #1;
    check({name, " q_hold"},    quotient,  eq);
    check({name, " r_hold"},    remainder, er);
  endtask

  initial begin
    int         cycles, pulses, busy_seen;
    logic       rs;
    logic [3:0] ra, rb;

    rst = 1'b1; start = 1'b0; S = 1'b0; i1 = 4'd0; i2 = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst quotient",  quotient,  4'd0);
    check("rst remainder", remainder, 4'd0);
    check("rst busy",      busy,      1'b0);
    check("rst done",      done,      1'b0);
    check("rst dbz",       dbz,       1'b0);
    check("rst ovf",       ovf,       1'b0);
    rst = 1'b0;

    // Directed cases.
    run_div("u13_3",   1'b0, 4'd13,     4'd3);
    run_div("s-7_2",   1'b1, 4'b1001,   4'b0010);
    run_div("dbz5",    1'b0, 4'd5,      4'd0);
    run_div("ovf",     1'b1, 4'b1000,   4'b1111);
    run_div("sdbz",    1'b1, 4'b1010,   4'd0);
    run_div("u15_1",   1'b0, 4'd15,     4'd1);
    run_div("u2_9",    1'b0, 4'd2,      4'd9);
    run_div("s7_-8",   1'b1, 4'b0111,   4'b1000);

    // Reset during the second CALC cycle aborts the operation.
    @(negedge clk);
    S = 1'b0; i1 = 4'd12; i2 = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("abort busy_pre", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort quotient",  quotient,  4'd0);
    check("abort remainder", remainder, 4'd0);
    check("abort busy",      busy,      1'b0);
    check("abort done",      done,      1'b0);
    check("abort dbz",       dbz,       1'b0);
    check("abort ovf",       ovf,       1'b0);
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort no_done", pulses, 0);
    run_div("after_abort", 1'b0, 4'd12, 4'd5);

    // A start held during an operation with new operands is ignored.
    @(negedge clk);
    S = 1'b0; i1 = 4'd14; i2 = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    S = 1'b1; i1 = 4'b1001; i2 = 4'b0011;
    cycles = 1;
    while (!done && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check("busystart latency",   cycles,    6);
    check("busystart quotient",  quotient,  4'd3);
    check("busystart remainder", remainder, 4'd2);
    pulses    = 0;
    busy_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) pulses++;
      if (busy) busy_seen++;
    end
    check("busystart extra_done", pulses,    0);
    check("busystart restart",    busy_seen, 0);

    // Randomized operations, with zero divisors and the overflow case mixed in.
    for (int n = 0; n < 60; n++) begin
      rs = 1'($urandom);
      ra = 4'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      if (n % 15 == 7) begin
        rs = 1'b1; ra = 4'b1000; rb = 4'b1111;
      end
      run_div($sformatf("rnd%0d S=%0d %0d/%0d", n, rs, ra, rb), rs, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Ports (name, direction, width, meaning):
 clk  in  1  rising-edge clock
 rst  in  1  synchronous active-high reset
 start  in  1  request a division; sampled only in IDLE
 S  in  1  1 = signed two's-complement operands, 0 = unsigned
 i1  in  4  dividend
 i2  in  4  divisor
 quotient  out  4  result quotient
 remainder  out  4  result remainder
 busy  out  1  high while a division is in progress
 done  out  1  one-cycle pulse: results valid
 dbz  out  1  divide-by-zero flag for the last result
 ovf  out  1  signed-overflow flag for the last result

Function
REQ-003 States SHALL be IDLE, CALC, FIX and DONE.
REQ-004 IDLE: start=1 at edge k SHALL latch S, operand signs and operand magnitudes (magnitude = two's complement when S=1 and the MSB=1).
 - Same edge: clear dbz/ovf; enter CALC; iteration count = 0.
REQ-005 Division by zero: start=1 with i2=0 at edge k SHALL bypass CALC and enter DONE.
 - quotient=4'hF, remainder=i1, dbz=1, ovf=0; done=1 in cycle k+1.
REQ-006 CALC SHALL perform one restoring shift-subtract step per clock for 4 clocks (edges k+1..k+4).
 - Partial remainder width 5 bits: shift left, bring in next dividend bit MSB-first.
 - Subtract divisor magnitude; if result >= 0 keep it and set quotient bit=1, else restore and set bit=0.
REQ-007 After the 4th step (edge k+4) SHALL enter FIX.
REQ-008 FIX (edge k+5): quotient is negated when S=1 and the operand signs differ; remainder is negated when S=1 and the dividend is negative.
 - Quotient is truncated toward zero.
 - Update quotient/remainder; enter DONE.
REQ-009 Signed overflow: S=1, i1=4'b1000, i2=4'b1111 SHALL yield quotient=4'b1000, remainder=0, ovf=1.
REQ-010 DONE SHALL assert done for exactly one cycle, then return to IDLE.
 - Normal latency: done high in cycle k+6 relative to start edge k (5 clock edges of busy).
REQ-011 busy SHALL be 1 in CALC and FIX, 0 in IDLE and DONE.
REQ-012 start SHALL be ignored while busy or done is high; no queuing.
REQ-013 quotient, remainder, dbz and ovf SHALL hold their last values until the next accepted start.
 - quotient/remainder update only in FIX or on the dbz path.
REQ-014 Operand changes on i1/i2/S after the start edge SHALL NOT affect the result in progress.
REQ-015 Unsigned mode SHALL treat all 4 bits as magnitude (range 0..15); no negation.

Reset
REQ-016 rst=1 at any edge SHALL force IDLE, iteration count=0, and quotient=0, remainder=0, busy=0, done=0, dbz=0, ovf=0; rst has priority over start.
REQ-017 Reset during CALC/FIX SHALL abort the operation; no done pulse follows.

Verification
REQ-018 Unsigned: S=0, i1=13, i2=3, start pulse -> busy 5 cycles, done pulse, quotient=4, remainder=1, dbz=0, ovf=0.
REQ-019 Signed: S=1, i1=4'b1001 (-7), i2=4'b0010 (2) -> quotient=4'b1101 (-3), remainder=4'b1111 (-1).
REQ-020 Divide by zero: S=0, i1=5, i2=0 -> done next cycle, busy never high, quotient=4'hF, remainder=5, dbz=1.
REQ-021 Overflow: S=1, i1=4'b1000, i2=4'b1111 -> quotient=4'b1000, remainder=0, ovf=1.
REQ-022 Reset mid-op: start 12/5, assert rst on 2nd CALC cycle -> all outputs 0 next cycle, no done pulse.
 - A new start afterwards yields q=2, r=2.
REQ-023 Busy start: second start with new operands during CALC -> ignored; first result delivered unchanged; exactly one done pulse.
